// File: rtl/seq_booth_multiplier.sv
// Sequential radix-2 Booth multiplier, signed or unsigned operands, one Booth step per cycle.
// Latency WIDTH+2 cycles from start to done; no backpressure, start is ignored while busy.
module seq_booth_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [WIDTH:0]       m_q, m_nxt;
  logic [WIDTH:0]       ac_q, ac_nxt;
  logic [WIDTH:0]       q_q, q_nxt;
  logic                 qres_q, qres_nxt;
  logic [CW-1:0]        cnt_q, cnt_nxt;
  logic [2*WIDTH-1:0]   out_q, out_nxt;
  logic [WIDTH:0]       sum;

  // Operands carry one extra bit so the most negative value and full-range
  // unsigned values both fit as signed WIDTH+1-bit quantities.
  always_comb begin
    case ({q_q[0], qres_q})
      2'b01:   sum = ac_q + m_q;
      2'b10:   sum = ac_q - m_q;
      default: sum = ac_q;
    endcase
  end

  always_comb begin
    state_nxt = state;
    m_nxt     = m_q;
    ac_nxt    = ac_q;
    q_nxt     = q_q;
    qres_nxt  = qres_q;
    cnt_nxt   = cnt_q;
    out_nxt   = out_q;
    busy      = (state != IDLE);
    done      = (state == DONE);

    case (state)
      IDLE: begin
        if (start) begin
          m_nxt     = is_signed ? {A[WIDTH-1], A} : {1'b0, A};
          q_nxt     = is_signed ? {B[WIDTH-1], B} : {1'b0, B};
          ac_nxt    = '0;
          qres_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Arithmetic right shift of {AC,Q,Qres}, AC MSB replicated.
        ac_nxt   = {sum[WIDTH], sum[WIDTH:1]};
        q_nxt    = {sum[0], q_q[WIDTH:1]};
        qres_nxt = q_q[0];
        cnt_nxt  = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          // Low 2*WIDTH bits of the shifted {AC,Q} pair.
          out_nxt   = {sum[WIDTH-1:0], q_q[WIDTH:1]};
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      m_q    <= '0;
      ac_q   <= '0;
      q_q    <= '0;
      qres_q <= 1'b0;
      cnt_q  <= '0;
      out_q  <= '0;
    end else begin
      state  <= state_nxt;
      m_q    <= m_nxt;
      ac_q   <= ac_nxt;
      q_q    <= q_nxt;
      qres_q <= qres_nxt;
      cnt_q  <= cnt_nxt;
      out_q  <= out_nxt;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed bench for seq_booth_multiplier at WIDTH=8: vector table plus
// hand-written sequences for busy-time start, mid-run reset and back-to-back use.
module tb_seq_booth_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           is_signed;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_booth_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .A         (a),
    .B         (b),
    .busy      (busy),
    .done      (done),
    .out       (out)
  );

  typedef struct {
    logic        sgn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; that cycle is cycle 0 (start high).
  // Returns at the falling edge of the cycle in which done is seen.
  task automatic run_op(input logic sgn, input logic [7:0] va, input logic [7:0] vb,
                        output int lat, output logic [15:0] prod);
    is_signed = sgn;
    a         = va;
    b         = vb;
    start     = 1'b1;
    lat       = -1;
    prod      = 16'hxxxx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat  = c;
        prod = out;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    logic [15:0] prod;
    int          ndone;
    int          dcyc;
    logic [15:0] dout;
    int          d1, d2;
    logic [15:0] o1, o2;

    vecs[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    vecs[1]  = '{1'b1, 8'h7F, 8'hFF, 16'hFF81};
    vecs[2]  = '{1'b0, 8'h7F, 8'hFF, 16'h7E81};
    vecs[3]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vecs[4]  = '{1'b0, 8'h00, 8'hA5, 16'h0000};
    vecs[5]  = '{1'b1, 8'h00, 8'h80, 16'h0000};
    vecs[6]  = '{1'b1, 8'h03, 8'h05, 16'h000F};
    vecs[7]  = '{1'b1, 8'hFD, 8'h05, 16'hFFF1};
    vecs[8]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    vecs[9]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
    vecs[10] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    vecs[11] = '{1'b1, 8'h9C, 8'h0A, 16'hFC18};

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out",  32'(out),  32'd0);
    rst = 1'b0;

    // First cycle out of reset: start is accepted immediately.
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, prod);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd10);
      check($sformatf("vec%0d_out", i), 32'(prod), 32'(vecs[i].exp));
      @(negedge clk);
      check($sformatf("vec%0d_done_width", i), 32'(done), 32'd0);
      check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
    end

    // Product register holds while idle with changing operands.
    a = 8'h55; b = 8'hAA; is_signed = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_out", 32'(out), 32'hFC18);

    // Start re-asserted with new operands during RUN.
    is_signed = 1'b1; a = 8'h03; b = 8'h05; start = 1'b1;
    ndone = 0; dcyc = -1; dout = '0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (done) begin ndone++; dcyc = c; dout = out; end
      start = 1'b0;
      if (c >= 2 && c <= 5) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; is_signed = 1'b0;
      end
    end
    check("busy_start_ndone", 32'(ndone), 32'd1);
    check("busy_start_cycle", 32'(dcyc), 32'd10);
    check("busy_start_out", 32'(dout), 32'h000F);

    // Reset in the 4th RUN cycle.
    is_signed = 1'b1; a = 8'h80; b = 8'h80; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("mid_reset_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_out",  32'(out),  32'd0);
    check("mid_reset_done", 32'(done), 32'd0);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mid_reset_no_done", 32'(ndone), 32'd0);
    check("mid_reset_out_kept", 32'(out), 32'd0);
    run_op(1'b0, 8'h12, 8'h34, lat, prod);
    check("post_reset_latency", 32'(lat), 32'd10);
    check("post_reset_out", 32'(prod), 32'h03A8);
    @(negedge clk);

    // Back-to-back: second start in the IDLE cycle right after DONE.
    is_signed = 1'b1; a = 8'h03; b = 8'h05; start = 1'b1;
    d1 = -1; d2 = -1; o1 = '0; o2 = '0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        if (d1 < 0) begin d1 = c; o1 = out; end
        else if (d2 < 0) begin d2 = c; o2 = out; end
      end
      if (c == 11) begin
        is_signed = 1'b1; a = 8'hFD; b = 8'h05; start = 1'b1;
      end
    end
    check("b2b_first_cycle", 32'(d1), 32'd10);
    check("b2b_first_out", 32'(o1), 32'h000F);
    check("b2b_gap", 32'(d2 - d1), 32'd11);
    check("b2b_second_out", 32'(o2), 32'hFFF1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
